multiplier_8bit: RTL
====================

MULTIPLIER_8BIT -- requirements
Module: multiplier_8bit

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand width in bits; product is 2*WIDTH bits.
REQ-002 SHALL provide port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port: strt  input  1  start request; sampled only in IDLE.
REQ-005 SHALL provide port: multiplicand  input  8  operand A (quotient side of the division identity).
REQ-006 SHALL provide port: multiplier  input  8  operand B (divisor side).
REQ-007 SHALL provide port: addend  input  8  operand C (remainder side), added once.
REQ-008 SHALL provide port: product  output  16  registered result A*B+C.
REQ-009 SHALL provide port: overflow  output  1  registered; high when product[15:8] nonzero, i.e. the result does not fit an 8-bit dividend.
REQ-010 SHALL provide port: done  output  1  registered one-cycle pulse coincident with a new product.
REQ-011 SHALL provide port: idle  output  1  high exactly when state is IDLE.

Function
REQ-012 SHALL implement states IDLE, CALC, POSTCALC.
- IDLE: every cycle load mcand_reg={8'h00,multiplicand}, mplier_reg=multiplier, acc={8'h00,addend}, count=0.
- IDLE with strt=1: go to POSTCALC if multiplicand==0 or multiplier==0, else go to CALC.
REQ-013 SHALL, in CALC, each cycle do: if mplier_reg[0], acc<=acc+mcand_reg; mcand_reg<<=1; mplier_reg>>=1; count<=count+1.
REQ-014 SHALL leave CALC for POSTCALC after the cycle in which mplier_reg[7:1]==0 or count==7 (early termination); CALC cycles n = index of multiplier MSB set + 1 (1..8).
REQ-015 SHALL, in POSTCALC, register product<=acc, overflow<=|acc[15:8], done<=1, and return to IDLE; done SHALL be 0 in every other cycle.
REQ-016 SHALL give latency: strt sampled at edge k; product/done valid after edge k+n+1, with n=0 for the zero-operand path.
REQ-017 SHALL use a 16-bit accumulator with no carry out: max 255*255+255=65280 (0xFF00) fits.
REQ-018 SHALL hold product and overflow stable between done pulses.
REQ-019 SHALL ignore strt and operand changes outside IDLE; operands are captured on the strt edge only.
REQ-020 SHALL accept strt in the IDLE cycle in which done is high (back-to-back operation, no dead cycle).

Reset
REQ-021 SHALL, on rst=1 at a clock edge, force state=IDLE, product=16'h0000, overflow=0, done=0, idle=1 on the next cycle.
REQ-022 SHALL treat rst during CALC or POSTCALC as an abort: no done pulse, product keeps its reset value 0.
REQ-023 SHALL NOT reset operand/working registers (acc, mcand_reg, mplier_reg, count); IDLE reloads them.
REQ-024 SHALL give rst priority over strt in the same cycle.

Structure
REQ-025 SHALL place state encodings (IDLE=2'b00, CALC=2'b01, POSTCALC=2'b10) and the width constant 8 in the shared arithmetic package used by the team's divider and multiplier.
REQ-026 SHALL be a single module; no sub-module is natural at this size.
REQ-027 SHALL contain no simulation-only dump statements in synthesizable code.

Verification
REQ-028 SHALL cover A=13, B=5, C=3 -> product 0x0044 (68), overflow 0, n=3, done 4 cycles after strt edge.
REQ-029 SHALL cover A=255, B=255, C=255 -> product 0xFF00, overflow 1, n=8, done 9 cycles after strt edge.
REQ-030 SHALL cover A=42, B=0, C=7 -> product 0x0007, overflow 0, done 1 cycle after strt edge (zero-operand path).
REQ-031 SHALL cover the round-trip case A=22, B=9, C=2 (200/9 result) -> product 0x00C8 (200), overflow 0; also back-to-back strt on the done cycle with A=1, B=128, C=0 -> 0x0080 after n=8.
REQ-032 SHALL cover rst pulsed in the 2nd CALC cycle of A=255, B=255 -> idle=1 next cycle, product 0x0000, no done; strt toggled mid-CALC -> no effect on result or latency.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic package for the team's shift-add multiplier and divider:
// common operand width and the sequencer state encoding.
package arith_pkg;

    localparam int unsigned ARITH_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_CALC     = 2'b01,
        ST_POSTCALC = 2'b10
    } arith_state_e;

endpackage

// File: rtl/multiplier_8bit.sv
// Sequential shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// The addend preloads the accumulator; the loop stops early once no multiplier bits remain.
module multiplier_8bit
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               strt,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   addend,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow,
    output logic               done,
    output logic               idle
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

    arith_state_e        state_r;
    arith_state_e        state_next_s;
    logic [2*WIDTH-1:0]  mcand_r;
    logic [WIDTH-1:0]    mplier_r;
    logic [2*WIDTH-1:0]  acc_r;
    logic [CW-1:0]       count_r;
    logic                finish_s;
    logic                zero_operand_s;
    logic [2*WIDTH-1:0]  product_r;
    logic                overflow_r;
    logic                done_r;
    logic                idle_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s   = state_r;
        zero_operand_s = (multiplicand == {WIDTH{1'b0}}) || (multiplier == {WIDTH{1'b0}});
        case (state_r)
            ST_IDLE: begin
                if (strt) begin
                    if (zero_operand_s) begin
                        state_next_s = ST_POSTCALC;
                    end else begin
                        state_next_s = ST_CALC;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                // Leave once the remaining multiplier bits are all zero.
                if ((mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}}) || (count_r == COUNT_LAST)) begin
                    state_next_s = ST_POSTCALC;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_POSTCALC: state_next_s = ST_IDLE;
            default:     state_next_s = ST_IDLE;
        endcase
    end

    // Output decode: result is published from the POSTCALC cycle
    always_comb begin
        finish_s = 1'b0;
        case (state_r)
            ST_POSTCALC: finish_s = 1'b1;
            default:     finish_s = 1'b0;
        endcase
    end

    // Working registers: reloaded every IDLE cycle, so no reset is needed
    always_ff @(posedge clk) begin
        case (state_r)
            ST_IDLE: begin
                mcand_r  <= {{WIDTH{1'b0}}, multiplicand};
                mplier_r <= multiplier;
                acc_r    <= {{WIDTH{1'b0}}, addend};
                count_r  <= {CW{1'b0}};
            end
            ST_CALC: begin
                if (mplier_r[0]) begin
                    acc_r <= acc_r + mcand_r;
                end
                mcand_r  <= mcand_r << 1;
                mplier_r <= mplier_r >> 1;
                count_r  <= count_r + CW'(1);
            end
            default: begin
                mcand_r  <= mcand_r;
                mplier_r <= mplier_r;
                acc_r    <= acc_r;
                count_r  <= count_r;
            end
        endcase
    end

    // Registered outputs; product/overflow hold between done pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            product_r  <= {(2*WIDTH){1'b0}};
            overflow_r <= 1'b0;
            done_r     <= 1'b0;
            idle_r     <= 1'b1;
        end else begin
            done_r <= finish_s;
            idle_r <= (state_next_s == ST_IDLE);
            if (finish_s) begin
                product_r  <= acc_r;
                overflow_r <= |acc_r[2*WIDTH-1:WIDTH];
            end else begin
                product_r  <= product_r;
                overflow_r <= overflow_r;
            end
        end
    end

    assign product  = product_r;
    assign overflow = overflow_r;
    assign done     = done_r;
    assign idle     = idle_r;

endmodule
